umi_endpoint_fifo: RTL



---
 rtl/umi_endpoint_fifo_if.sv | 41 ++++
 rtl/umi_endpoint_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/umi_endpoint_fifo_if.sv
// UMI device-port bundle: request channel into the endpoint and the
// response channel back out of it. The endpoint uses the slave view.
interface umi_endpoint_fifo_if #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);
  logic          udev_req_valid;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr;
  logic [AW-1:0] udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_req_ready;

  logic          udev_resp_valid;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr;
  logic [AW-1:0] udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;
  logic          udev_resp_ready;

  // Crossbar side: issues requests, sinks responses
  modport master (
    output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
           udev_req_data,
    input  udev_req_ready,
    input  udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
           udev_resp_srcaddr, udev_resp_data,
    output udev_resp_ready
  );

  // Endpoint side: accepts requests, sources responses
  modport slave (
    input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
           udev_req_data,
    output udev_req_ready,
    output udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
           udev_resp_srcaddr, udev_resp_data,
    input  udev_resp_ready
  );
endinterface

// File: rtl/umi_endpoint_fifo.sv
// UMI device endpoint with up to DEPTH outstanding responses.
// Requests are turned into local memory strobes; responding ops travel
// down an RDLAT-deep in-flight pipe, pick up read data at its end and land
// in a response FIFO. A credit count (in-flight + queued) gates request
// acceptance so the FIFO can never overflow.
module umi_endpoint_fifo #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int DEPTH = 4,
  parameter int RDLAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  umi_endpoint_fifo_if.slave udev,
  output logic [AW-1:0] loc_addr,
  output logic          loc_write,
  output logic          loc_read,
  output logic [7:0]    loc_opcode,
  output logic [2:0]    loc_size,
  output logic [7:0]    loc_len,
  output logic [DW-1:0] loc_wrdata,
  input  logic [DW-1:0] loc_rddata,
  input  logic          loc_ready,
  output logic          err_drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW = $clog2(DEPTH + 1);

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  logic [UW-1:0] used;
  logic [UW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          accept;
  logic          is_read;
  logic          is_write;
  logic          is_posted;
  logic          is_resp_op;
  logic          resp_accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] resp_cmd;
  logic [DW-1:0] push_data;

  logic          pipe_valid [RDLAT];
  logic          pipe_read  [RDLAT];
  logic [CW-1:0] pipe_cmd   [RDLAT];
  logic [AW-1:0] pipe_dst   [RDLAT];
  logic [AW-1:0] pipe_src   [RDLAT];

  logic [CW-1:0] mem_cmd  [DEPTH];
  logic [AW-1:0] mem_dst  [DEPTH];
  logic [AW-1:0] mem_src  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  // Opcode decode and acceptance; ready never looks at valid or opcode
  assign is_read     = (udev.udev_req_cmd[4:0] == REQ_READ);
  assign is_write    = (udev.udev_req_cmd[4:0] == REQ_WRITE);
  assign is_posted   = (udev.udev_req_cmd[4:0] == REQ_POSTED);
  assign is_resp_op  = is_read | is_write;

  assign udev.udev_req_ready = ~reset & loc_ready & (used < UW'(DEPTH));
  assign accept      = udev.udev_req_valid & udev.udev_req_ready;
  assign resp_accept = accept & is_resp_op;

  assign loc_addr   = udev.udev_req_dstaddr;
  assign loc_wrdata = udev.udev_req_data;
  assign loc_opcode = {3'b000, udev.udev_req_cmd[4:0]};
  assign loc_size   = udev.udev_req_cmd[7:5];
  assign loc_len    = udev.udev_req_cmd[15:8];
  assign loc_read   = accept & is_read;
  assign loc_write  = accept & (is_write | is_posted);

  assign resp_cmd = {udev.udev_req_cmd[CW-1:5], is_read ? RESP_READ : RESP_WRITE};

  // Tail of the in-flight pipe is the FIFO push; read data is sampled here
  assign push      = pipe_valid[RDLAT-1];
  assign push_data = pipe_read[RDLAT-1] ? loc_rddata : '0;

  assign udev.udev_resp_valid   = (fifo_count != '0);
  assign udev.udev_resp_cmd     = mem_cmd[rd_ptr];
  assign udev.udev_resp_dstaddr = mem_dst[rd_ptr];
  assign udev.udev_resp_srcaddr = mem_src[rd_ptr];
  assign udev.udev_resp_data    = mem_data[rd_ptr];
  assign pop = udev.udev_resp_valid & udev.udev_resp_ready;

  // In-flight pipe: one stage per cycle of local read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RDLAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_read[i]  <= 1'b0;
        pipe_cmd[i]   <= '0;
        pipe_dst[i]   <= '0;
        pipe_src[i]   <= '0;
      end
    end else begin
      pipe_valid[0] <= resp_accept;
      pipe_read[0]  <= is_read;
      pipe_cmd[0]   <= resp_cmd;
      pipe_dst[0]   <= udev.udev_req_srcaddr;
      pipe_src[0]   <= udev.udev_req_dstaddr;
      for (int i = 1; i < RDLAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_read[i]  <= pipe_read[i-1];
        pipe_cmd[i]   <= pipe_cmd[i-1];
        pipe_dst[i]   <= pipe_dst[i-1];
        pipe_src[i]   <= pipe_src[i-1];
      end
    end
  end

  // Response storage; contents need no reset because the count gates valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr]  <= pipe_cmd[RDLAT-1];
      mem_dst[wr_ptr]  <= pipe_dst[RDLAT-1];
      mem_src[wr_ptr]  <= pipe_src[RDLAT-1];
      mem_data[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + UW'(1);
        2'b01:   fifo_count <= fifo_count - UW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credits: taken by a responding accept, returned by a response pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used <= '0;
    end else begin
      case ({resp_accept, pop})
        2'b10:   used <= used + UW'(1);
        2'b01:   used <= used - UW'(1);
        default: used <= used;
      endcase
    end
  end

  // Unsupported request consumed: flag it one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_drop <= 1'b0;
    end else begin
      err_drop <= accept & ~is_resp_op & ~is_posted;
    end
  end

  // Credit accounting guarantees a free slot for every push
  push_into_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (fifo_count == UW'(DEPTH))));

endmodule
